// File: rtl/hfuse_frame_feedback.sv
// rtl/hfuse_frame_feedback.sv - fused-frame store that feeds the fusion datapath and drains the final frame
// Seeds memory from image 0, then re-reads and re-captures it for each later image.
module hfuse_frame_feedback #(
  parameter int FUSEDIMAGE_DATA_WIDTH = 8,
  parameter int HIM_LEN               = 520,
  parameter int HIM_WID               = 520,
  parameter int LOG2_NO_OF_IMAGES     = 4,
  parameter int FUSE_LAT              = 21
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             pix_valid,
  input  logic [7:0]                       hnew_in,
  input  logic [FUSEDIMAGE_DATA_WIDTH-1:0] hfused_in,
  output logic [FUSEDIMAGE_DATA_WIDTH-1:0] hfuse_out,
  output logic [7:0]                       hnew_out,
  output logic                             hvalid_out,
  output logic [LOG2_NO_OF_IMAGES-1:0]     frame_idx,
  output logic                             frame_done,
  output logic [FUSEDIMAGE_DATA_WIDTH-1:0] out_pix,
  output logic                             out_valid,
  output logic                             all_done
);

  localparam int NPIX = HIM_LEN * HIM_WID;
  localparam int AW   = 19;
  localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);

  typedef enum logic [2:0] {IDLE, SEED, RUN, FLUSH, DRAIN, DONE} state_t;

  state_t                           state;
  logic [AW-1:0]                    rd_addr;
  logic [AW-1:0]                    wr_addr;
  logic [FUSE_LAT-1:0]              dl;
  logic [FUSEDIMAGE_DATA_WIDTH-1:0] mem [0:NPIX-1];
  logic                             we;
  logic [FUSEDIMAGE_DATA_WIDTH-1:0] wdata;

  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + AW'(1);
  endfunction

  // Seed writes come straight from the pixel input; later frames write when the delay line tail fires.
  always_comb begin
    we    = 1'b0;
    wdata = hfused_in;
    if (!rst) begin
      if (state == SEED) begin
        we    = pix_valid;
        wdata = FUSEDIMAGE_DATA_WIDTH'(hnew_in);
      end else if (state == RUN || state == FLUSH) begin
        we = dl[FUSE_LAT-1];
      end
    end
  end

  assign frame_done = we && (wr_addr == LAST_ADDR);

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rd_addr    <= '0;
      wr_addr    <= '0;
      dl         <= '0;
      hfuse_out  <= '0;
      hnew_out   <= '0;
      hvalid_out <= 1'b0;
      frame_idx  <= '0;
      out_pix    <= '0;
      out_valid  <= 1'b0;
      all_done   <= 1'b0;
    end else begin
      hvalid_out <= 1'b0;
      out_valid  <= 1'b0;
      dl[0]      <= hvalid_out;
      for (int i = 1; i < FUSE_LAT; i++) dl[i] <= dl[i-1];
      if (we) wr_addr <= next_addr(wr_addr);

      case (state)
        IDLE: begin
          if (start) begin
            state     <= SEED;
            frame_idx <= '0;
            rd_addr   <= '0;
            wr_addr   <= '0;
          end
        end
        SEED: begin
          if (frame_done) begin
            state     <= RUN;
            frame_idx <= LOG2_NO_OF_IMAGES'(1);
            rd_addr   <= '0;
          end
        end
        RUN: begin
          if (pix_valid) begin
            hfuse_out  <= mem[rd_addr];
            hnew_out   <= hnew_in;
            hvalid_out <= 1'b1;
            rd_addr    <= next_addr(rd_addr);
            if (rd_addr == LAST_ADDR) state <= FLUSH;
          end
        end
        FLUSH: begin
          // Hold here until the in-flight fused pixels of this frame have all landed.
          if (frame_done) begin
            rd_addr <= '0;
            if (&frame_idx) begin
              state <= DRAIN;
            end else begin
              frame_idx <= frame_idx + LOG2_NO_OF_IMAGES'(1);
              state     <= RUN;
            end
          end
        end
        DRAIN: begin
          out_pix   <= mem[rd_addr];
          out_valid <= 1'b1;
          rd_addr   <= next_addr(rd_addr);
          if (rd_addr == LAST_ADDR) state <= DONE;
        end
        DONE: begin
          if (start) begin
            state     <= SEED;
            all_done  <= 1'b0;
            frame_idx <= '0;
            rd_addr   <= '0;
            wr_addr   <= '0;
          end else begin
            all_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hfuse_frame_feedback.sv
// tb/tb_hfuse_frame_feedback.sv - scoreboard bench for hfuse_frame_feedback on a 4x4, 4-image, FUSE_LAT=3 setup
module tb_hfuse_frame_feedback;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       pix_valid = 1'b0;
  logic [7:0] hnew_in = '0;
  logic [7:0] hfused_in = '0;
  logic [7:0] hfuse_out;
  logic [7:0] hnew_out;
  logic       hvalid_out;
  logic [1:0] frame_idx;
  logic       frame_done;
  logic [7:0] out_pix;
  logic       out_valid;
  logic       all_done;

  int checks = 0;
  int errors = 0;

  logic [15:0] h_q [$];
  logic [7:0]  o_q [$];
  logic [1:0]  fd_q [$];
  logic [15:0] h_e;
  logic [7:0]  o_e;
  logic [1:0]  fd_e;
  logic        pv_q = 1'b0;
  logic [7:0]  p0 = '0, p1 = '0, p2 = '0;

  hfuse_frame_feedback #(
    .FUSEDIMAGE_DATA_WIDTH(8),
    .HIM_LEN(4),
    .HIM_WID(4),
    .LOG2_NO_OF_IMAGES(2),
    .FUSE_LAT(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .pix_valid(pix_valid),
    .hnew_in(hnew_in),
    .hfused_in(hfused_in),
    .hfuse_out(hfuse_out),
    .hnew_out(hnew_out),
    .hvalid_out(hvalid_out),
    .frame_idx(frame_idx),
    .frame_done(frame_done),
    .out_pix(out_pix),
    .out_valid(out_valid),
    .all_done(all_done)
  );

  always #5 clk = ~clk;

  function automatic void check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Fusion datapath model: hfuse + hnew returned three cycles after hvalid_out.
  always @(posedge clk) begin
    #1;
    hfused_in = p2;
    p2 = p1;
    p1 = p0;
    p0 = hfuse_out + hnew_out;
  end

  always @(posedge clk) pv_q <= pix_valid;

  // Monitor: pops the scoreboard whenever the DUT presents something.
  always @(negedge clk) begin
    if (!rst) begin
      if (hvalid_out) begin
        check("hvalid_follows_pix_valid", int'(pv_q), 1);
        if (h_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL hvalid_unexpected: got pixel hfuse=%0d hnew=%0d expected none", hfuse_out, hnew_out);
        end else begin
          h_e = h_q.pop_front();
          check("hfuse_out", int'(hfuse_out), int'(h_e[15:8]));
          check("hnew_out", int'(hnew_out), int'(h_e[7:0]));
        end
      end
      if (out_valid) begin
        if (o_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL out_unexpected: got out_pix=%0d expected none", out_pix);
        end else begin
          o_e = o_q.pop_front();
          check("out_pix", int'(out_pix), int'(o_e));
        end
      end
      if (frame_done) begin
        if (fd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL frame_done_unexpected: got frame_idx=%0d expected none", frame_idx);
        end else begin
          fd_e = fd_q.pop_front();
          check("frame_done_idx", int'(frame_idx), int'(fd_e));
        end
      end
    end
  end

  task automatic issue_start_and_seed();
    @(posedge clk); #1;
    start = 1'b1; pix_valid = 1'b1; hnew_in = 8'd99;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      start = 1'b0; pix_valid = 1'b1; hnew_in = 8'(k);
      if (k == 0) begin
        check("start_frame_idx", int'(frame_idx), 0);
        check("start_all_done", int'(all_done), 0);
      end
    end
  endtask

  task automatic run_seq(input bit gapped, input bit noise);
    int cnt;
    int n;
    for (int f = 1; f < 4; f++)
      for (int k = 0; k < 16; k++) h_q.push_back({8'(k + f - 1), 8'd1});
    for (int k = 0; k < 16; k++) o_q.push_back(8'(k + 3));
    for (int f = 0; f < 4; f++) fd_q.push_back(2'(f));
    issue_start_and_seed();
    cnt = 0;
    while (!out_valid && cnt < 400) begin
      @(posedge clk); #1;
      pix_valid = gapped ? !pix_valid : 1'b1;
      hnew_in   = 8'd1;
      start     = noise;
      cnt++;
    end
    start = 1'b0; pix_valid = 1'b0;
    check("drain_reached", int'(cnt < 400), 1);
    n = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      n += int'(out_valid);
    end
    check("drain_length", n, 16);
    @(negedge clk);
    check("out_valid_after_drain", int'(out_valid), 0);
    check("all_done", int'(all_done), 1);
    check("final_frame_idx", int'(frame_idx), 3);
    check("hvalid_count", h_q.size(), 0);
    check("out_count", o_q.size(), 0);
    check("frame_done_count", fd_q.size(), 0);
  endtask

  task automatic run_reset();
    for (int k = 0; k < 16; k++) h_q.push_back({8'(k), 8'd1});
    for (int k = 0; k < 7; k++) h_q.push_back({8'(k + 1), 8'd1});
    fd_q.push_back(2'd0);
    fd_q.push_back(2'd1);
    issue_start_and_seed();
    // frame 1 (16), flush (4), frame 2 pixels 0..6
    for (int i = 0; i < 27; i++) begin
      @(posedge clk); #1;
      pix_valid = 1'b1; hnew_in = 8'd1;
    end
    @(posedge clk); #1;
    pix_valid = 1'b1; hnew_in = 8'd1;
    @(negedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_hvalid_out", int'(hvalid_out), 0);
    check("rst_hfuse_out", int'(hfuse_out), 0);
    check("rst_hnew_out", int'(hnew_out), 0);
    check("rst_frame_idx", int'(frame_idx), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_all_done", int'(all_done), 0);
    check("pixels_before_reset", h_q.size(), 0);
    check("frames_before_reset", fd_q.size(), 0);
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    // Idle after reset: pixels without start must produce nothing.
    repeat (6) begin
      @(posedge clk); #1;
      pix_valid = 1'b1;
    end
    pix_valid = 1'b0;
    @(negedge clk);
    check("idle_frame_done", int'(frame_done), 0);
    check("idle_all_done", int'(all_done), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_hvalid_out", int'(hvalid_out), 0);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_all_done", int'(all_done), 0);
    check("reset_frame_idx", int'(frame_idx), 0);
    check("reset_frame_done", int'(frame_done), 0);
    check("reset_out_pix", int'(out_pix), 0);
    #1; rst = 1'b0;
    run_seq(1'b0, 1'b1);
    run_seq(1'b1, 1'b0);
    run_reset();
    run_seq(1'b0, 1'b0);
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
